nios_audio_system_au_out: RTL

Avalon-MM slave audio output port: the playback counterpart of the audio input PIO. The Nios CPU writes 16-bit samples into a small FIFO. The DAC-side logic pulls one sample per `sample_req` strobe onto `out_port`. The block sits between the Nios data master and the codec serializer, in the same clock domain as the audio input port.

---
 rtl/nios_audio_system_au_out_pkg.sv | 32 +++
 rtl/nios_audio_system_au_out_fifo.sv | 78 +++++++
 rtl/nios_audio_system_au_out.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nios_audio_system_au_out_pkg.sv
// Shared constants for the audio output port: register map, bit positions, default sizes.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package audio_out_pkg;

    // Default geometry
    localparam int AU_DATA_W_DEF = 16;
    localparam int AU_DEPTH_DEF  = 16;

    // Register addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    // Status register bit positions (level occupies [LW-1:0])
    localparam int STAT_EMPTY = 8;
    localparam int STAT_FULL  = 9;
    localparam int STAT_UNDER = 10;
    localparam int STAT_OVER  = 11;

    // Control register bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Level counter width: one extra bit so a full FIFO (level == DEPTH) is representable
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/nios_audio_system_au_out_fifo.sv
// Register-array FIFO with flush; head entry is visible combinationally, no read latency.
// Latency: push visible at head on the edge after it is stored; pop consumes head on its edge.
// Backpressure: none; push on full is refused unless a same-cycle pop frees a slot, flush wins over both.
module au_out_fifo
    import audio_out_pkg::*;
#(
    parameter int DATA_W = AU_DATA_W_DEF,
    parameter int DEPTH  = AU_DEPTH_DEF,
    parameter int LW     = level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head,
    output logic [LW-1:0]     o_level,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_push_ok,
    output logic              o_pop_ok
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    // The level counter alone decides full/empty; pointers only address the array
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    assign w_push_ok = i_push & ~i_flush & (~w_full | w_pop_ok);

    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_push_ok = w_push_ok;
    assign o_pop_ok  = w_pop_ok;

    // Storage array: contents need no reset, pointers/level define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers wrap naturally modulo DEPTH; flush and reset empty the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/nios_audio_system_au_out.sv
// Avalon-MM audio output port: CPU pushes samples into a FIFO, DAC strobes pop them onto out_port.
// Latency: readdata one edge after address; out_port updates on the sample_req edge; irq one edge after its condition.
// Backpressure: none; overflow/underflow are recorded in sticky flags. Low-water irq built only with AU_OUT_IRQ_EN.
module nios_audio_system_au_out
    import audio_out_pkg::*;
#(
    parameter int DATA_W = AU_DATA_W_DEF,
    parameter int DEPTH  = AU_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              sample_req,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    localparam int LW = level_w(DEPTH);

    logic              r_enable;
    logic              r_underflow;
    logic              r_overflow;
    logic [DATA_W-1:0] r_out_port;
    logic [31:0]       r_readdata;

    logic              w_wr;
    logic              w_push;
    logic              w_wr_status;
    logic              w_wr_ctrl;
    logic              w_flush;
    logic              w_pop_req;
    logic [DATA_W-1:0] w_head;
    logic [LW-1:0]     w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_over_evt;
    logic              w_under_evt;
    logic              w_irq_en;
    logic [LW-1:0]     w_thresh;
    logic [31:0]       w_rd_mux;

    assign w_wr        = chipselect & ~write_n;
    assign w_push      = w_wr & (address == ADDR_DATA);
    assign w_wr_status = w_wr & (address == ADDR_STATUS);
    assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
    assign w_flush     = w_wr_ctrl & writedata[CTRL_FLUSH];
    assign w_pop_req   = sample_req & r_enable;

    // A discarded push during flush is not an overflow, and a flush suppresses the pop entirely
    assign w_over_evt  = w_push & ~w_flush & ~w_push_ok;
    assign w_under_evt = w_pop_req & w_empty & ~w_flush;

    au_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LW     (LW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_dat     (writedata[DATA_W-1:0]),
        .i_pop     (w_pop_req),
        .i_flush   (w_flush),
        .o_head    (w_head),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok)
    );

    // Control enable bit; flush is a pulse and is never stored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_enable <= 1'b0;
        else if (w_wr_ctrl) r_enable <= writedata[CTRL_ENABLE];
    end

    // Sticky error flags: write-1-to-clear, a same-cycle new event keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_under_evt)                                r_underflow <= 1'b1;
            else if (w_wr_status && writedata[STAT_UNDER])  r_underflow <= 1'b0;
            if (w_over_evt)                                 r_overflow  <= 1'b1;
            else if (w_wr_status && writedata[STAT_OVER])   r_overflow  <= 1'b0;
        end
    end

    // Sample presented to the DAC: advances only on a successful pop, otherwise holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_out_port <= '0;
        else if (w_pop_ok) r_out_port <= w_head;
    end

`ifdef AU_OUT_IRQ_EN
    logic          r_irq_en;
    logic [LW-1:0] r_thresh;
    logic          r_irq;

    // Interrupt enable and low-water threshold registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_thresh <= '0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= writedata[CTRL_IRQ_EN];
            if (w_wr & (address == ADDR_THRESH)) r_thresh <= writedata[LW-1:0];
        end
    end

    // Registered low-water interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else r_irq <= r_irq_en & r_enable & ((w_level <= r_thresh) | r_underflow);
    end

    assign w_irq_en = r_irq_en;
    assign w_thresh = r_thresh;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign w_thresh = '0;
    assign irq      = 1'b0;
`endif

    // Read mux: decoded from address every cycle, independent of chipselect
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:   w_rd_mux[DATA_W-1:0] = r_out_port;
            ADDR_STATUS: begin
                w_rd_mux[LW-1:0]   = w_level;
                w_rd_mux[STAT_EMPTY] = w_empty;
                w_rd_mux[STAT_FULL]  = w_full;
                w_rd_mux[STAT_UNDER] = r_underflow;
                w_rd_mux[STAT_OVER]  = r_overflow;
            end
            ADDR_CTRL: begin
                w_rd_mux[CTRL_ENABLE] = r_enable;
                w_rd_mux[CTRL_IRQ_EN] = w_irq_en;
            end
            ADDR_THRESH: w_rd_mux[LW-1:0] = w_thresh;
            default:     w_rd_mux = '0;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else r_readdata <= w_rd_mux;
    end

    assign readdata = r_readdata;
    assign out_port = r_out_port;

endmodule
